// File: rtl/sm_addsub_pkg.sv
// Shared ALU function codes for the signed-magnitude add/subtract unit.
// The control FSM and the datapath both import these constants.
package sm_addsub_pkg;

  localparam logic [2:0] ALU_PASS_INC = 3'b000;
  localparam logic [2:0] ALU_ADD      = 3'b001;
  localparam logic [2:0] ALU_SUB      = 3'b010;
  localparam logic [2:0] ALU_DEC      = 3'b011;
  localparam logic [2:0] ALU_PASSB    = 3'b100;
  localparam logic [2:0] ALU_CMPA     = 3'b111;

endpackage

// File: rtl/sm_addsub_datapath_if.sv
// Strobe/operand/status bundle between the control FSM (master) and the datapath (slave).
// The avf status line exists only when SMDP_OVERFLOW_EN is defined.
interface sm_addsub_datapath_if #(parameter int WIDTH = 4);

  logic [WIDTH-1:0] a_in;
  logic             as_in;
  logic [WIDTH-1:0] b_in;
  logic             bs_in;
  logic             S2, S1, S0, Cin;
  logic             L, X, Y, Z, W;
  logic             S;
  logic             E;
  logic [WIDTH-1:0] a_out;
  logic             as_out;
`ifdef SMDP_OVERFLOW_EN
  logic             avf;
`endif

  modport master (
    output a_in, as_in, b_in, bs_in, S2, S1, S0, Cin, L, X, Y, Z, W,
    input  S, E, a_out, as_out
`ifdef SMDP_OVERFLOW_EN
    , input avf
`endif
  );

  modport slave (
    input  a_in, as_in, b_in, bs_in, S2, S1, S0, Cin, L, X, Y, Z, W,
    output S, E, a_out, as_out
`ifdef SMDP_OVERFLOW_EN
    , output avf
`endif
  );

endinterface

// File: rtl/sm_alu.sv
// Combinational ALU for the datapath: WIDTH+1 bit sum, carry taken from bit WIDTH.
module sm_alu
  import sm_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] cin_ext;

  assign cin_ext = {{WIDTH{1'b0}}, cin};

  // Pass/complement functions never produce a carry, so Cin is ignored for them.
  always_comb begin
    sum = '0;
    case (sel)
      ALU_PASS_INC: sum = {1'b0, a} + cin_ext;
      ALU_ADD:      sum = {1'b0, a} + {1'b0, b} + cin_ext;
      ALU_SUB:      sum = {1'b0, a} + {1'b0, ~b} + cin_ext;
      ALU_DEC:      sum = {1'b0, a} + {1'b0, {WIDTH{1'b1}}} + cin_ext;
      ALU_CMPA:     sum = {1'b0, ~a};
      ALU_PASSB:    sum = {1'b0, b};
      default:      sum = {1'b0, b};
    endcase
  end

  assign result = sum[WIDTH-1:0];
  assign carry  = sum[WIDTH];

endmodule

// File: rtl/sm_addsub_datapath.sv
// Register/ALU datapath of the signed-magnitude add/subtract unit.
// Optional AVF overflow flop and avf output are built when SMDP_OVERFLOW_EN is defined.
module sm_addsub_datapath
  import sm_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sm_addsub_datapath_if.slave  bus
);

  logic [WIDTH-1:0] a_q;
  logic             as_q;
  logic [WIDTH-1:0] b_q;
  logic             bs_q;
  logic             e_q;
  logic [2:0]       sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             a_is_zero;

  assign sel       = {bus.S2, bus.S1, bus.S0};
  assign a_is_zero = (a_q == '0);

  sm_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .sel    (sel),
    .cin    (bus.Cin),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Priority: reset, then X, then the independent L/Y/Z/W group.
  // W tests the registered A, so it sees the value before a coinciding L.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      as_q <= 1'b0;
      b_q  <= '0;
      bs_q <= 1'b0;
      e_q  <= 1'b0;
    end else if (bus.X) begin
      a_q  <= bus.a_in;
      as_q <= bus.as_in;
      b_q  <= bus.b_in;
      bs_q <= bus.bs_in;
      e_q  <= 1'b0;
    end else begin
      if (bus.L) begin
        a_q <= alu_result;
        if (sel == ALU_ADD || sel == ALU_SUB) begin
          e_q <= alu_carry;
        end
      end
      if (bus.Y) begin
        bs_q <= ~bs_q;
      end
      if (bus.Z) begin
        as_q <= ~as_q;
      end
      if (bus.W && a_is_zero) begin
        as_q <= 1'b0;
      end
    end
  end

`ifdef SMDP_OVERFLOW_EN
  logic avf_q;

  // Sticky: once an add overflows, it stays set until new operands arrive.
  always_ff @(posedge clk) begin
    if (reset || bus.X) begin
      avf_q <= 1'b0;
    end else if (bus.L && sel == ALU_ADD && alu_carry) begin
      avf_q <= 1'b1;
    end
  end

  assign bus.avf = avf_q;
`endif

  assign bus.S      = as_q ^ bs_q;
  assign bus.E      = e_q;
  assign bus.a_out  = a_q;
  assign bus.as_out = as_q;

endmodule

// File: tb/tb_sm_addsub_datapath.sv
// Self-checking bench for sm_addsub_datapath: directed cases plus random strobes, scoreboard-checked.
// Define SMDP_OVERFLOW_EN on both RTL and bench to exercise the avf output.
module tb_sm_addsub_datapath;

  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  typedef struct {
    int a;
    int as_;
    int e;
    int s;
    int avf;
  } exp_t;

  logic clk;
  logic reset;
  int   num_checks;
  int   num_errors;
  exp_t sbq[$];

  // Reference model state
  int m_a, m_as, m_b, m_bs, m_e, m_avf;

  sm_addsub_datapath_if #(.WIDTH(WIDTH)) bus ();

  sm_addsub_datapath #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic compareScoreboard(input string tag);
    exp_t ex;
    if (sbq.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 0, 1);
      return;
    end
    ex = sbq.pop_front();
    checkOutput({tag, "_A"},  int'(bus.a_out),  ex.a);
    checkOutput({tag, "_As"}, int'(bus.as_out), ex.as_);
    checkOutput({tag, "_E"},  int'(bus.E),      ex.e);
    checkOutput({tag, "_S"},  int'(bus.S),      ex.s);
`ifdef SMDP_OVERFLOW_EN
    checkOutput({tag, "_avf"}, int'(bus.avf),   ex.avf);
`endif
  endtask

  // Drives one cycle of strobes, advances the model, then checks the registered result.
  task automatic applyStimulus(input string tag, input logic rst, input logic x, input logic l,
                               input logic y, input logic z, input logic w,
                               input logic [2:0] sel, input logic cin,
                               input logic as_i, input logic [WIDTH-1:0] a_i,
                               input logic bs_i, input logic [WIDTH-1:0] b_i);
    exp_t ex;
    int   r;
    int   old_a;
    @(negedge clk);
    reset      = rst;
    bus.X      = x;
    bus.L      = l;
    bus.Y      = y;
    bus.Z      = z;
    bus.W      = w;
    {bus.S2, bus.S1, bus.S0} = sel;
    bus.Cin    = cin;
    bus.as_in  = as_i;
    bus.a_in   = a_i;
    bus.bs_in  = bs_i;
    bus.b_in   = b_i;

    if (rst) begin
      m_a = 0; m_as = 0; m_b = 0; m_bs = 0; m_e = 0; m_avf = 0;
    end else if (x) begin
      m_a = int'(a_i); m_as = int'(as_i); m_b = int'(b_i); m_bs = int'(bs_i);
      m_e = 0; m_avf = 0;
    end else begin
      old_a = m_a;
      if (l) begin
        case (sel)
          3'd0:    r = m_a + int'(cin);
          3'd1:    r = m_a + m_b + int'(cin);
          3'd2:    r = m_a + (MASK - m_b) + int'(cin);
          3'd3:    r = m_a + MASK + int'(cin);
          3'd7:    r = MASK - m_a;
          default: r = m_b;
        endcase
        m_a = r % (MASK + 1);
        if (sel == 3'd1 || sel == 3'd2) m_e = (r > MASK) ? 1 : 0;
        if (sel == 3'd1 && r > MASK) m_avf = 1;
      end
      if (y) m_bs = 1 - m_bs;
      if (z) m_as = 1 - m_as;
      if (w && old_a == 0) m_as = 0;
    end
    ex.a = m_a; ex.as_ = m_as; ex.e = m_e; ex.s = m_as ^ m_bs; ex.avf = m_avf;
    sbq.push_back(ex);

    @(posedge clk);
    #1;
    compareScoreboard(tag);
  endtask

  task automatic loadOps(input string tag, input logic as_i, input logic [WIDTH-1:0] a_i,
                         input logic bs_i, input logic [WIDTH-1:0] b_i);
    applyStimulus(tag, 0, 1, 0, 0, 0, 0, 3'd0, 0, as_i, a_i, bs_i, b_i);
  endtask

  task automatic aluOp(input string tag, input logic l, input logic [2:0] sel, input logic cin,
                       input logic y, input logic z, input logic w);
    applyStimulus(tag, 0, 0, l, y, z, w, sel, cin, 0, '0, 0, '0);
  endtask

  initial begin
    num_checks = 0;
    num_errors = 0;
    m_a = 0; m_as = 0; m_b = 0; m_bs = 0; m_e = 0; m_avf = 0;

    applyStimulus("rst0", 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, '0, 0, '0);
    applyStimulus("rst1", 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, '0, 0, '0);
    checkOutput("reset_A", int'(bus.a_out), 0);
    checkOutput("reset_S", int'(bus.S), 0);

    // Case 1: +5 + +3
    loadOps("t1_x", 0, 4'd5, 0, 4'd3);
    aluOp("t1_add", 1, 3'b001, 0, 0, 0, 0);
    checkOutput("t1_A", int'(bus.a_out), 8);
    checkOutput("t1_E", int'(bus.E), 0);

    // Case 2: +5 - +3
    loadOps("t2_x", 0, 4'd5, 0, 4'd3);
    aluOp("t2_y", 0, 3'b000, 0, 1, 0, 0);
    checkOutput("t2_S", int'(bus.S), 1);
    aluOp("t2_sub", 1, 3'b010, 1, 0, 0, 0);
    checkOutput("t2_A", int'(bus.a_out), 2);
    checkOutput("t2_E", int'(bus.E), 1);

    // Case 3: +3 - +5, recomplement then fix sign
    loadOps("t3_x", 0, 4'd3, 0, 4'd5);
    aluOp("t3_y", 0, 3'b000, 0, 1, 0, 0);
    aluOp("t3_sub", 1, 3'b010, 1, 0, 0, 0);
    checkOutput("t3_A_sub", int'(bus.a_out), 14);
    checkOutput("t3_E_sub", int'(bus.E), 0);
    aluOp("t3_cmp", 1, 3'b111, 1, 0, 0, 0);
    checkOutput("t3_A_cmp", int'(bus.a_out), 1);
    aluOp("t3_inc", 1, 3'b000, 1, 0, 1, 0);
    checkOutput("t3_A_inc", int'(bus.a_out), 2);
    checkOutput("t3_As", int'(bus.as_out), 1);

    // Case 4: -5 + +5 gives zero; W removes negative zero
    loadOps("t4_x", 1, 4'd5, 0, 4'd5);
    aluOp("t4_sub", 1, 3'b010, 1, 0, 0, 0);
    checkOutput("t4_A", int'(bus.a_out), 0);
    checkOutput("t4_E", int'(bus.E), 1);
    aluOp("t4_w", 0, 3'b000, 0, 0, 0, 1);
    checkOutput("t4_As", int'(bus.as_out), 0);

    // Case 5: +9 + +9 wraps
    loadOps("t5_x", 0, 4'd9, 0, 4'd9);
    aluOp("t5_add", 1, 3'b001, 0, 0, 0, 0);
    checkOutput("t5_A", int'(bus.a_out), 2);
    checkOutput("t5_E", int'(bus.E), 1);
    aluOp("t5_hold", 1, 3'b100, 0, 0, 0, 0);
`ifdef SMDP_OVERFLOW_EN
    checkOutput("t5_avf_sticky", int'(bus.avf), 1);
`endif
    loadOps("t5_x2", 0, 4'd1, 0, 4'd1);
`ifdef SMDP_OVERFLOW_EN
    checkOutput("t5_avf_clr", int'(bus.avf), 0);
`endif

    // Case 6: reset wins over X and L mid-operation
    loadOps("t6_x", 1, 4'd5, 0, 4'd3);
    aluOp("t6_y", 0, 3'b000, 0, 1, 0, 0);
    applyStimulus("t6_rst", 1, 1, 1, 0, 0, 0, 3'b001, 1, 1, 4'd7, 1, 4'd6);
    checkOutput("t6_A", int'(bus.a_out), 0);
    checkOutput("t6_S", int'(bus.S), 0);
    checkOutput("t6_E", int'(bus.E), 0);

    // W coinciding with L tests the pre-update A
    loadOps("t7_x", 1, 4'd0, 0, 4'd4);
    aluOp("t7_lw", 1, 3'b001, 0, 0, 0, 1);
    checkOutput("t7_As", int'(bus.as_out), 0);
    checkOutput("t7_A", int'(bus.a_out), 4);

    // Random strobe mix against the model
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rnd", ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    3'($urandom), 1'($urandom),
                    1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
    end

    checkOutput("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
